zkbdmus_fifo: RTL and testbench

ZKBDMUS_FIFO -- requirements
Module: zkbdmus_fifo

---
 rtl/zkbdmus_fifo_if.sv | 36 +++
 rtl/zkbdmus_fifo.sv | 80 ++++++++
 tb/tb_zkbdmus_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/zkbdmus_fifo_if.sv
// Keyboard matrix, Kempston mouse and scancode FIFO signal bundle.
// master drives stimulus and host reads; slave is the peripheral side.
interface zkbdmus_fifo_if #(
    parameter int KCOLS = 5
);
    logic [8*KCOLS-1:0] kbd_in;
    logic               kbd_stb;
    logic [7:0]         mus_in;
    logic               mus_xstb;
    logic               mus_ystb;
    logic               mus_btnstb;
    logic               mus_mode;
    logic [7:0]         code_in;
    logic               code_stb;
    logic               code_rd;
    logic               code_clr;
    logic [15:8]        za;
    logic [KCOLS-1:0]   kbd_data;
    logic [7:0]         mus_data;
    logic [7:0]         code_data;
    logic               code_empty;
    logic               code_full;
    logic               code_ovf;

    modport master (
        output kbd_in, kbd_stb, mus_in, mus_xstb, mus_ystb, mus_btnstb, mus_mode,
               code_in, code_stb, code_rd, code_clr, za,
        input  kbd_data, mus_data, code_data, code_empty, code_full, code_ovf
    );

    modport slave (
        input  kbd_in, kbd_stb, mus_in, mus_xstb, mus_ystb, mus_btnstb, mus_mode,
               code_in, code_stb, code_rd, code_clr, za,
        output kbd_data, mus_data, code_data, code_empty, code_full, code_ovf
    );
endinterface

// File: rtl/zkbdmus_fifo.sv
// Keyboard matrix latch, Kempston mouse registers and a first-word-fall-through
// scancode FIFO sharing one clock domain.
module zkbdmus_fifo #(
    parameter int KCOLS      = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           fclk,
    input  logic           rst,
    zkbdmus_fifo_if.slave  bus
);
    localparam int IW = $clog2(FIFO_DEPTH);

    logic [8*KCOLS-1:0] kbd_q;
    logic [7:0]         mus_x, mus_y, mus_btn;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [IW:0]        wr_ptr, rd_ptr, occ;
    logic               ovf_q;
    logic               empty, full, do_push, do_pop;
    logic [KCOLS-1:0]   kd;

    // ---------------- keyboard ----------------
    always_ff @(posedge fclk) begin
        if (rst)              kbd_q <= '0;
        else if (bus.kbd_stb) kbd_q <= bus.kbd_in;
    end

    // Column j is pulled low when any selected (za low) row has that key pressed.
    always_comb begin
        kd = '1;
        for (int j = 0; j < KCOLS; j++)
            for (int r = 0; r < 8; r++)
                if (!bus.za[8+r] && kbd_q[r + 8*(KCOLS-1-j)]) kd[j] = 1'b0;
    end
    assign bus.kbd_data = kd;

    // ---------------- mouse ----------------
    always_ff @(posedge fclk) begin
        if (rst) begin
            mus_x   <= 8'h00;
            mus_y   <= 8'h00;
            mus_btn <= 8'hFF;
        end else begin
            if (bus.mus_btnstb) mus_btn <= bus.mus_in;
            if (bus.mus_xstb)   mus_x   <= bus.mus_mode ? mus_x + bus.mus_in : bus.mus_in;
            if (bus.mus_ystb)   mus_y   <= bus.mus_mode ? mus_y + bus.mus_in : bus.mus_in;
        end
    end

    assign bus.mus_data = !bus.za[8] ? mus_btn : (bus.za[10] ? mus_y : mus_x);

    // ---------------- scancode FIFO ----------------
    assign occ   = wr_ptr - rd_ptr;
    assign empty = (occ == '0);
    assign full  = (occ == (IW+1)'(FIFO_DEPTH));

    // A pop frees the slot a same-cycle push needs when full; pop on empty is dropped.
    assign do_pop  = bus.code_rd && !empty;
    assign do_push = bus.code_stb && (!full || do_pop);

    always_ff @(posedge fclk) begin
        if (rst || bus.code_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (IW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (IW+1)'(1);
            if (bus.code_stb && !do_push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge fclk) begin
        if (!rst && !bus.code_clr && do_push) mem[wr_ptr[IW-1:0]] <= bus.code_in;
    end

    assign bus.code_data  = empty ? 8'h00 : mem[rd_ptr[IW-1:0]];
    assign bus.code_empty = empty;
    assign bus.code_full  = full;
    assign bus.code_ovf   = ovf_q;
endmodule

// File: tb/tb_zkbdmus_fifo.sv
// Randomized bench for zkbdmus_fifo against a queue-based reference model.
module tb_zkbdmus_fifo;
    localparam int KC = 5;
    localparam int D  = 8;

    logic fclk = 1'b0;
    logic rst  = 1'b1;
    always #5 fclk = ~fclk;

    zkbdmus_fifo_if #(.KCOLS(KC)) bus();
    zkbdmus_fifo #(.KCOLS(KC), .FIFO_DEPTH(D)) dut (.fclk(fclk), .rst(rst), .bus(bus.slave));

    int errors = 0;
    int checks = 0;

    // reference state
    logic [8*KC-1:0] m_kbd;
    logic [7:0]      m_x, m_y, m_btn;
    logic            m_ovf;
    logic [7:0]      q[$];

    function automatic logic [KC-1:0] exp_kbd(input logic [7:0] zhi);
        logic [KC-1:0] v = '1;
        for (int j = 0; j < KC; j++)
            for (int r = 0; r < 8; r++)
                if (zhi[r] == 1'b0 && m_kbd[r + 8*(KC-1-j)]) v[j] = 1'b0;
        return v;
    endfunction

    function automatic logic [7:0] exp_mus(input logic [7:0] zhi);
        if (!zhi[0]) return m_btn;
        return zhi[2] ? m_y : m_x;
    endfunction

    function automatic logic [7:0] exp_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    task automatic idle();
        bus.kbd_stb = 0; bus.mus_xstb = 0; bus.mus_ystb = 0; bus.mus_btnstb = 0;
        bus.code_stb = 0; bus.code_rd = 0; bus.code_clr = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at that edge.
    task automatic step();
        bit pop, push;
        if (rst) begin
            m_kbd = '0; m_x = 8'h00; m_y = 8'h00; m_btn = 8'hFF; m_ovf = 0; q.delete();
        end else begin
            if (bus.kbd_stb)    m_kbd = bus.kbd_in;
            if (bus.mus_btnstb) m_btn = bus.mus_in;
            if (bus.mus_xstb)   m_x = bus.mus_mode ? 8'(m_x + bus.mus_in) : bus.mus_in;
            if (bus.mus_ystb)   m_y = bus.mus_mode ? 8'(m_y + bus.mus_in) : bus.mus_in;
            if (bus.code_clr) begin
                q.delete(); m_ovf = 0;
            end else begin
                pop  = bus.code_rd && q.size() > 0;
                push = bus.code_stb && (q.size() < D || pop);
                if (bus.code_stb && !push) m_ovf = 1;
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(bus.code_in);
            end
        end
        @(posedge fclk);
        #1;
    endtask

    task automatic test_reset();
        idle(); bus.kbd_in = '1; bus.mus_in = 8'h55; bus.mus_mode = 0; bus.code_in = 8'h11;
        bus.za = 8'hFF;
        rst = 1; bus.kbd_stb = 1; bus.code_stb = 1; bus.mus_xstb = 1;
        step(); step();
        rst = 0; idle(); bus.za = 8'h00; #1;
        checks++; if (bus.kbd_data !== 5'h1F) begin errors++; $display("FAIL reset_kbd got %h want %h", bus.kbd_data, 5'h1F); end
        checks++; if (bus.mus_data !== 8'hFF) begin errors++; $display("FAIL reset_btn got %h want %h", bus.mus_data, 8'hFF); end
        checks++; if (bus.code_empty !== 1'b1 || bus.code_full !== 1'b0 || bus.code_ovf !== 1'b0)
            begin errors++; $display("FAIL reset_flags got e%b f%b o%b want e1 f0 o0", bus.code_empty, bus.code_full, bus.code_ovf); end
        checks++; if (bus.code_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.code_data); end
        bus.za = 8'hFB; #1;
        checks++; if (bus.mus_data !== 8'h00) begin errors++; $display("FAIL reset_x got %h want 00", bus.mus_data); end
    endtask

    task automatic test_kbd();
        idle(); bus.kbd_in = 40'h1; bus.kbd_stb = 1; step(); idle();
        bus.za = 8'hFE; #1;
        checks++; if (bus.kbd_data !== 5'b01111) begin errors++; $display("FAIL kbd_row0 got %b want 01111", bus.kbd_data); end
        bus.za = 8'hFD; #1;
        checks++; if (bus.kbd_data !== 5'b11111) begin errors++; $display("FAIL kbd_row1 got %b want 11111", bus.kbd_data); end
        for (int i = 0; i < 12; i++) begin
            bus.kbd_in = {8'($urandom), $urandom}; bus.kbd_stb = (i % 3) != 2; step(); idle();
            for (int k = 0; k < 3; k++) begin
                bus.za = 8'($urandom); if (k == 0) bus.za = 8'hFF; #1;
                checks++; if (bus.kbd_data !== exp_kbd(bus.za))
                    begin errors++; $display("FAIL kbd_rand za=%h got %b want %b", bus.za, bus.kbd_data, exp_kbd(bus.za)); end
            end
        end
    endtask

    task automatic test_mouse();
        idle(); bus.mus_mode = 0; bus.mus_in = 8'hFE; bus.mus_xstb = 1; step();
        idle(); bus.mus_mode = 1; bus.mus_in = 8'h05; bus.mus_xstb = 1; step(); idle();
        bus.za = 8'hFB; #1;
        checks++; if (bus.mus_data !== 8'h03) begin errors++; $display("FAIL mus_delta got %h want 03", bus.mus_data); end
        for (int i = 0; i < 40; i++) begin
            bus.mus_mode = 1'($urandom); bus.mus_in = 8'($urandom);
            bus.mus_xstb = 1'($urandom); bus.mus_ystb = 1'($urandom); bus.mus_btnstb = ($urandom_range(0, 3) == 0);
            step(); idle();
            bus.za = 8'hFE; #1;
            checks++; if (bus.mus_data !== m_btn) begin errors++; $display("FAIL mus_btn got %h want %h", bus.mus_data, m_btn); end
            bus.za = 8'hFB; #1;
            checks++; if (bus.mus_data !== m_x) begin errors++; $display("FAIL mus_x got %h want %h", bus.mus_data, m_x); end
            bus.za = 8'hFF; #1;
            checks++; if (bus.mus_data !== m_y) begin errors++; $display("FAIL mus_y got %h want %h", bus.mus_data, m_y); end
        end
    endtask

    task automatic test_fifo_fill();
        idle();
        for (int i = 1; i <= 8; i++) begin bus.code_in = 8'(i); bus.code_stb = 1; step(); end
        idle(); #1;
        checks++; if (bus.code_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.code_full); end
        bus.code_in = 8'h09; bus.code_stb = 1; step(); idle();
        checks++; if (bus.code_ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf got %b want 1", bus.code_ovf); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (bus.code_data !== 8'(i)) begin errors++; $display("FAIL fill_pop got %h want %h", bus.code_data, 8'(i)); end
            bus.code_rd = 1; step(); idle();
        end
        checks++; if (bus.code_empty !== 1'b1 || bus.code_data !== 8'h00)
            begin errors++; $display("FAIL fill_drain got e%b d%h want e1 d00", bus.code_empty, bus.code_data); end
        bus.code_rd = 1; bus.code_stb = 1; bus.code_in = 8'h5A; step(); idle();
        checks++; if (bus.code_data !== 8'h5A || bus.code_empty !== 1'b0)
            begin errors++; $display("FAIL empty_pushpop got d%h e%b want d5A e0", bus.code_data, bus.code_empty); end
        bus.code_clr = 1; step(); idle();
    endtask

    task automatic test_full_simul();
        idle();
        for (int i = 0; i < 8; i++) begin bus.code_in = 8'h10 + 8'(i); bus.code_stb = 1; step(); end
        bus.code_in = 8'hAA; bus.code_stb = 1; bus.code_rd = 1; step(); idle();
        checks++; if (bus.code_full !== 1'b1 || bus.code_ovf !== 1'b0)
            begin errors++; $display("FAIL simul_flags got f%b o%b want f1 o0", bus.code_full, bus.code_ovf); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] want;
            want = (i == 7) ? 8'hAA : 8'h11 + 8'(i);
            checks++; if (bus.code_data !== want) begin errors++; $display("FAIL simul_pop got %h want %h", bus.code_data, want); end
            bus.code_rd = 1; step(); idle();
        end
    endtask

    task automatic test_clr();
        idle();
        for (int i = 0; i < 9; i++) begin bus.code_in = 8'(i); bus.code_stb = 1; step(); end
        bus.code_clr = 1; bus.code_stb = 1; bus.code_rd = 1; bus.code_in = 8'h77; step(); idle();
        checks++; if (bus.code_empty !== 1'b1 || bus.code_ovf !== 1'b0)
            begin errors++; $display("FAIL clr got e%b o%b want e1 o0", bus.code_empty, bus.code_ovf); end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 400; i++) begin
            bus.code_in  = 8'($urandom);
            bus.code_stb = ($urandom_range(0, 9) < 6);
            bus.code_rd  = ($urandom_range(0, 9) < 4 + (i / 100) % 2 * 3);
            bus.code_clr = ($urandom_range(0, 63) == 0);
            bus.mus_in = 8'($urandom); bus.mus_mode = 1'($urandom); bus.mus_xstb = 1'($urandom);
            step(); idle();
            bus.za = 8'($urandom); #1;
            checks++; if (bus.code_data !== exp_head() || bus.code_empty !== (q.size() == 0) ||
                          bus.code_full !== (q.size() == D) || bus.code_ovf !== m_ovf)
                begin errors++; $display("FAIL rand_fifo cyc%0d got d%h e%b f%b o%b want d%h n%0d o%b",
                    i, bus.code_data, bus.code_empty, bus.code_full, bus.code_ovf, exp_head(), q.size(), m_ovf); end
            if (i % 8 == 0) begin
                checks++; if (bus.mus_data !== exp_mus(bus.za))
                    begin errors++; $display("FAIL rand_mus got %h want %h", bus.mus_data, exp_mus(bus.za)); end
            end
        end
    endtask

    task automatic test_rst_mid();
        idle(); bus.code_clr = 1; step(); idle();
        bus.mus_mode = 0; bus.mus_in = 8'h40; bus.mus_xstb = 1; step(); idle();
        bus.mus_in = 8'h12; bus.mus_btnstb = 1; bus.kbd_in = '1; bus.kbd_stb = 1; step(); idle();
        for (int i = 0; i < 3; i++) begin bus.code_in = 8'hC0 + 8'(i); bus.code_stb = 1; step(); end
        rst = 1; bus.mus_xstb = 1; bus.mus_in = 8'h33; step(); rst = 0; idle();
        bus.za = 8'hFB; #1;
        checks++; if (bus.mus_data !== 8'h00) begin errors++; $display("FAIL rst_x got %h want 00", bus.mus_data); end
        bus.za = 8'h00; #1;
        checks++; if (bus.mus_data !== 8'hFF) begin errors++; $display("FAIL rst_btn got %h want FF", bus.mus_data); end
        checks++; if (bus.kbd_data !== 5'h1F) begin errors++; $display("FAIL rst_kbd got %b want 11111", bus.kbd_data); end
        checks++; if (bus.code_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", bus.code_empty); end
    endtask

    initial begin
        test_reset();
        test_kbd();
        test_mouse();
        test_fifo_fill();
        test_full_simul();
        test_clr();
        test_random();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
